// File: rtl/dvp_camera_emulator_pkg.sv
// Shared definitions for the DVP camera emulator: FSM state encoding,
// RGB565 colour-bar constants and byte-select helpers.
package dvp_camera_emulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_V_BACK,
        ST_ACTIVE,
        ST_HBLANK,
        ST_V_FRONT
    } emu_state_e;

    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;

    // Index 0 is the leftmost bar.
    localparam logic [7:0][15:0] BAR_COLORS = {
        RGB565_BLACK, RGB565_BLUE, RGB565_RED, RGB565_MAGENTA,
        RGB565_GREEN, RGB565_CYAN, RGB565_YELLOW, RGB565_WHITE
    };

    function automatic logic [7:0] RGB565_HI(input logic [15:0] p);
        return p[15:8];
    endfunction

    function automatic logic [7:0] RGB565_LO(input logic [15:0] p);
        return p[7:0];
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_emu_pattern.sv
// Combinational test-pattern generator: (x, y, frame) -> RGB565 pixel.
// CAM_EMU_COLOR_BARS_EN selects eight vertical colour bars instead of the gradient.
module cam_emu_pattern
    import dvp_camera_emulator_pkg::*;
#(
    parameter int FRAME_WIDTH = 640,
    parameter int XW          = 10,
    parameter int YW          = 9
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [7:0]    f_i,
    output logic [15:0]   pix_o
);
    logic [15:0] x_ext;
    logic [15:0] y_ext;
    logic        unused_pattern;

    assign x_ext = 16'(x_i);
    assign y_ext = 16'(y_i);

`ifdef CAM_EMU_COLOR_BARS_EN
    localparam int BAR_W = (FRAME_WIDTH / 8 < 1) ? 1 : FRAME_WIDTH / 8;
    logic [15:0] bar_idx;

    // Rounding leftovers on the right edge fold into the last (black) bar.
    assign bar_idx        = x_ext / 16'(BAR_W);
    assign pix_o          = (bar_idx > 16'd7) ? BAR_COLORS[7] : BAR_COLORS[bar_idx[2:0]];
    assign unused_pattern = ^{y_ext, f_i};
`else
    assign pix_o          = {x_ext[4:0], y_ext[5:0], f_i[4:0]};
    assign unused_pattern = ^{x_ext[15:5], y_ext[15:6], f_i[7:5], 16'(FRAME_WIDTH), BAR_COLORS[0]};
`endif

endmodule

// File: rtl/dvp_camera_emulator.sv
// OV7670-style DVP source: frame/line timing FSM, counters and RGB565 byte mux.
// Pattern selection via CAM_EMU_COLOR_BARS_EN (see cam_emu_pattern).
module dvp_camera_emulator
    import dvp_camera_emulator_pkg::*;
#(
    parameter int FRAME_WIDTH   = 640,
    parameter int FRAME_HEIGHT  = 480,
    parameter int H_BLANK       = 288,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK_LINES  = 17,
    parameter int V_FRONT_LINES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       cam_vsync,
    output logic       href,
    output logic [7:0] p_data,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);
    localparam int LINE_LEN = 2 * FRAME_WIDTH + H_BLANK;
    localparam int CW       = $clog2(LINE_LEN);
    localparam int LMAX     = max_int(max_int(FRAME_HEIGHT, VSYNC_LINES),
                                      max_int(V_BACK_LINES, V_FRONT_LINES));
    localparam int LNW      = (LMAX > 1) ? $clog2(LMAX) : 1;

    localparam logic [CW-1:0]  COL_LINE_END = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0]  COL_ACT_END  = CW'(2 * FRAME_WIDTH - 1);
    localparam logic [CW-1:0]  COL_HBL_END  = CW'(H_BLANK - 1);
    localparam logic [LNW-1:0] VS_END       = LNW'(VSYNC_LINES - 1);
    localparam logic [LNW-1:0] VB_END       = LNW'(V_BACK_LINES - 1);
    localparam logic [LNW-1:0] VF_END       = LNW'(V_FRONT_LINES - 1);
    localparam logic [LNW-1:0] ACT_LAST     = LNW'(FRAME_HEIGHT - 1);

    // Zero-length sync/porch phases are skipped by jumping straight past them.
    localparam emu_state_e FRAME_START = (VSYNC_LINES > 0)  ? ST_VSYNC  :
                                         (V_BACK_LINES > 0) ? ST_V_BACK : ST_ACTIVE;
    localparam emu_state_e AFTER_VSYNC = (V_BACK_LINES > 0) ? ST_V_BACK : ST_ACTIVE;

    emu_state_e     state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [LNW-1:0] line_q, line_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           frame_end;
    logic           line_wrap;
    logic [15:0]    pix;

    logic           vsync_q, href_q, done_q;
    logic [7:0]     data_q, fcnt_q;

    cam_emu_pattern #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .XW          (CW - 1),
        .YW          (LNW)
    ) u_pattern (
        .x_i   (col_q[CW-1:1]),
        .y_i   (line_q),
        .f_i   (cnt_q),
        .pix_o (pix)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q + 1'b1;
        line_d    = line_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        line_wrap = (col_q == COL_LINE_END);
        case (state_q)
            ST_IDLE: begin
                col_d = '0;
                if (enable) state_d = FRAME_START;
            end
            ST_VSYNC: if (line_wrap) begin
                col_d  = '0;
                line_d = line_q + 1'b1;
                if (line_q == VS_END) begin
                    line_d  = '0;
                    state_d = AFTER_VSYNC;
                end
            end
            ST_V_BACK: if (line_wrap) begin
                col_d  = '0;
                line_d = line_q + 1'b1;
                if (line_q == VB_END) begin
                    line_d  = '0;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: if (col_q == COL_ACT_END) begin
                col_d   = '0;
                state_d = ST_HBLANK;
            end
            // line_q carries the active line index across ACTIVE/HBLANK.
            ST_HBLANK: if (col_q == COL_HBL_END) begin
                col_d = '0;
                if (line_q == ACT_LAST) begin
                    line_d = '0;
                    if (V_FRONT_LINES > 0) state_d = ST_V_FRONT;
                    else                   frame_end = 1'b1;
                end else begin
                    line_d  = line_q + 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_V_FRONT: if (line_wrap) begin
                col_d  = '0;
                line_d = line_q + 1'b1;
                if (line_q == VF_END) begin
                    line_d    = '0;
                    frame_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (frame_end) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = enable ? FRAME_START : ST_IDLE;
        end
    end

    // Outputs are registered decodes of the current state, one edge behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            vsync_q <= (state_q == ST_VSYNC);
            href_q  <= (state_q == ST_ACTIVE);
            data_q  <= (state_q != ST_ACTIVE) ? 8'h00 :
                       col_q[0] ? RGB565_LO(pix) : RGB565_HI(pix);
            done_q  <= frame_end;
            fcnt_q  <= cnt_q;
        end
    end

    assign cam_vsync  = vsync_q;
    assign href       = href_q;
    assign p_data     = data_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_dvp_camera_emulator.sv
// Scoreboard bench for dvp_camera_emulator on a tiny frame (L=12 / 60-cycle frame,
// or W=8 when CAM_EMU_COLOR_BARS_EN is defined).
module tb_dvp_camera_emulator;
`ifdef CAM_EMU_COLOR_BARS_EN
    localparam int W = 8;
`else
    localparam int W = 4;
`endif
    localparam int H  = 2;
    localparam int HB = 4;
    localparam int V  = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = 2 * W + HB;
    localparam int FP = (V + VB + H + VF) * L;
    localparam int NB = 2 * W;

    logic       clk, reset, enable;
    logic       cam_vsync, href, frame_done;
    logic [7:0] p_data, frame_cnt;

    int         checks   = 0;
    int         failures = 0;
    logic       started  = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] tbl [4][16];
    logic [7:0] abort_byte;

    dvp_camera_emulator #(
        .FRAME_WIDTH   (W),
        .FRAME_HEIGHT  (H),
        .H_BLANK       (HB),
        .VSYNC_LINES   (V),
        .V_BACK_LINES  (VB),
        .V_FRONT_LINES (VF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cam_vsync  (cam_vsync),
        .href       (href),
        .p_data     (p_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] outs();
        return {cam_vsync, href, p_data, frame_done, frame_cnt};
    endfunction

    // Expected {vsync, href, frame_done, frame_cnt} for output cycle k (k=1 is first vsync cycle).
    function automatic logic [10:0] exp_tl(input int k);
        int   p, a;
        logic v, h, fd;
        p  = (k - 1) % FP + 1;
        a  = p - (V + VB) * L - 1;
        v  = (p <= V * L);
        h  = (a >= 0) && (a < H * L) && ((a % L) < 2 * W);
        fd = (p == FP);
        return {v, h, fd, 8'((k - 1) / FP)};
    endfunction

    // Monitor: every href byte is popped from the scoreboard; blank bytes must be zero.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                if (href === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL href_byte: got %02h with no byte expected", p_data);
                    end else begin
                        chk("href_byte", 32'(p_data), 32'(exp_q.pop_front()));
                    end
                end else begin
                    chk("blank_data", 32'(p_data), 32'h0);
                end
            end
        end
    end

    initial begin
        bit seen;
        reset  = 1'b1;
        enable = 1'b1;
`ifdef CAM_EMU_COLOR_BARS_EN
        for (int i = 0; i < 4; i++)
            tbl[i] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                       8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        abort_byte = 8'hFF;
`else
        tbl[0] = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h18, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{8'h00, 8'h20, 8'h08, 8'h20, 8'h10, 8'h20, 8'h18, 8'h20,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{8'h00, 8'h01, 8'h08, 8'h01, 8'h10, 8'h01, 8'h18, 8'h01,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3] = '{8'h00, 8'h21, 8'h08, 8'h21, 8'h10, 8'h21, 8'h18, 8'h21,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        abort_byte = 8'h00;
`endif

        // Reset held with enable high: everything stays at zero.
        for (int i = 0; i < 3; i++) begin
            tick();
            started = 1'b1;
            chk("reset_outputs", 32'(outs()), 32'h0);
        end

        // Two back-to-back frames; enable drops halfway through the second.
        for (int f = 0; f < 2; f++)
            for (int y = 0; y < H; y++)
                for (int b = 0; b < NB; b++)
                    exp_q.push_back(tbl[f * H + y][b]);
        reset = 1'b0;
        tick();
        chk("first_edge_idle", 32'(outs()), 32'h0);
        for (int k = 1; k <= 2 * FP; k++) begin
            tick();
            chk($sformatf("timeline_k%0d", k),
                32'({cam_vsync, href, frame_done, frame_cnt}), 32'(exp_tl(k)));
            if (k == FP + FP / 2) enable = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_after_drop", 32'(outs()), 32'd2);
        end

        // Reset during the first active byte of a new frame aborts it.
        exp_q.push_back(abort_byte);
        enable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 3 * FP && !seen; i++) begin
            tick();
            if (href === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_href: no href within %0d cycles", 3 * FP);
        end
        reset = 1'b1;
        tick();
        chk("abort_outputs", 32'(outs()), 32'h0);
        tick();
        reset  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < FP + 10; i++) begin
            tick();
            chk("post_abort", 32'({cam_vsync, href, frame_done, frame_cnt}), 32'h0);
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
